key_password_lock: RTL

KEY_PASSWORD_LOCK -- requirements
Module: key_password_lock

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/tick_timer.sv | 43 ++++
 rtl/key_password_lock.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad lock: key codes, FSM states, timer width.
package keypad_pkg;

   localparam int unsigned TIMER_W = 16;
   localparam int unsigned DIGITS  = 4;

   localparam logic [3:0] KEY_ENTER = 4'hA;
   localparam logic [3:0] KEY_BKSP  = 4'hB;
   localparam logic [3:0] KEY_CLR   = 4'hC;

   typedef enum logic [1:0] {
      S_ENTRY   = 2'd0,
      S_OPEN    = 2'd1,
      S_LOCKOUT = 2'd2
   } state_e;

   // Codes 0..9 are digits; A..C are commands; D..F are ignored everywhere.
   function automatic logic is_digit(input logic [3:0] k);
      return (k <= 4'd9);
   endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
module tick_timer
   import keypad_pkg::*;
#(
   parameter int unsigned W = TIMER_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         done_o
);

   logic [W-1:0] count_q, count_d;
   logic         done_q,  done_d;

   // done is tracked alongside the count so it stays a registered flag.
   always_comb begin
      count_d = count_q;
      done_d  = done_q;
      if (load_i) begin
         count_d = load_val_i;
         done_d  = (load_val_i == '0);
      end else if (en_i && !done_q) begin
         count_d = count_q - W'(1);
         done_d  = (count_q == W'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         done_q  <= 1'b1;
      end else begin
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   assign done_o = done_q;

endmodule

// File: rtl/key_password_lock.sv
// Four-digit keypad lock: digit entry buffer, code compare, open window and
// lockout after too many wrong codes.
module key_password_lock
   import keypad_pkg::*;
#(
   parameter logic [15:0] PASSWORD      = 16'h1234,
   parameter int unsigned MAX_TRIES     = 3,
   parameter int unsigned OPEN_TICKS    = 500,
   parameter int unsigned LOCKOUT_TICKS = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  key_value,
   input  logic        key_valid,
   output logic [15:0] entry_buf,
   output logic [2:0]  digit_cnt,
   output logic        unlock,
   output logic        alarm,
   output logic        err_pulse,
   output logic [3:0]  fail_cnt
);

   localparam logic [2:0] FULL_CNT = 3'(DIGITS);

   state_e               state_q, state_d;
   logic [15:0]          buf_q, buf_d;
   logic [2:0]           cnt_q, cnt_d;
   logic [3:0]           fail_q, fail_d;
   logic                 err_q, err_d;
   logic                 unlock_q, alarm_q;
   logic                 tmr_load, tmr_en, tmr_done;
   logic [TIMER_W-1:0]   tmr_val;
   logic [3:0]           fail_inc;

   assign fail_inc = fail_q + 4'd1;
   assign tmr_en   = (state_q != S_ENTRY);

   tick_timer #(.W(TIMER_W)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .en_i       (tmr_en),
      .done_o     (tmr_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_ENTRY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      cnt_d    = cnt_q;
      fail_d   = fail_q;
      err_d    = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      unique case (state_q)
         S_ENTRY: begin
            if (key_valid) begin
               if (is_digit(key_value)) begin
                  if (cnt_q < FULL_CNT) begin
                     buf_d = {buf_q[11:0], key_value};
                     cnt_d = cnt_q + 3'd1;
                  end
               end else if (key_value == KEY_ENTER) begin
                  if (cnt_q == FULL_CNT) begin
                     buf_d = '0;
                     cnt_d = '0;
                     if (buf_q == PASSWORD) begin
                        state_d  = S_OPEN;
                        tmr_load = 1'b1;
                        tmr_val  = TIMER_W'(OPEN_TICKS - 1);
                        fail_d   = '0;
                     end else begin
                        err_d = 1'b1;
                        if (fail_inc == 4'(MAX_TRIES)) begin
                           state_d  = S_LOCKOUT;
                           tmr_load = 1'b1;
                           tmr_val  = TIMER_W'(LOCKOUT_TICKS - 1);
                           fail_d   = '0;
                        end else begin
                           fail_d = fail_inc;
                        end
                     end
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (key_value == KEY_BKSP) begin
                  if (cnt_q != 3'd0) begin
                     buf_d = {4'h0, buf_q[15:4]};
                     cnt_d = cnt_q - 3'd1;
                  end
               end else if (key_value == KEY_CLR) begin
                  buf_d = '0;
                  cnt_d = '0;
               end
            end
         end
         S_OPEN: begin
            // Expiry takes priority over a coincident key.
            if (tmr_done) begin
               state_d = S_ENTRY;
            end else if (key_valid && (key_value == KEY_CLR)) begin
               state_d  = S_ENTRY;
               tmr_load = 1'b1;
            end
         end
         S_LOCKOUT: begin
            if (tmr_done) begin
               state_d = S_ENTRY;
               buf_d   = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_ENTRY;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q    <= '0;
         cnt_q    <= '0;
         fail_q   <= '0;
         err_q    <= 1'b0;
         unlock_q <= 1'b0;
         alarm_q  <= 1'b0;
      end else begin
         buf_q    <= buf_d;
         cnt_q    <= cnt_d;
         fail_q   <= fail_d;
         err_q    <= err_d;
         unlock_q <= (state_d == S_OPEN);
         alarm_q  <= (state_d == S_LOCKOUT);
      end
   end

   assign entry_buf = buf_q;
   assign digit_cnt = cnt_q;
   assign fail_cnt  = fail_q;
   assign err_pulse = err_q;
   assign unlock    = unlock_q;
   assign alarm     = alarm_q;

endmodule
